// File: rtl/stack_unit.sv
// Register-file operand stack: one push/pop/replace/binop/dup/swap/clear per clock,
// with TOS/NOS read ports, sticky overflow/underflow flags and a high-water mark.
module stack_unit #(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = 16,
  parameter int PTR_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic [REG_BITS-1:0]   wdata,
  input  logic                  clear_err,
  output logic [REG_BITS-1:0]   tos,
  output logic [REG_BITS-1:0]   nos,
  output logic [PTR_BITS:0]     count,
  output logic                  empty,
  output logic                  full,
  output logic                  op_ok,
  output logic                  op_err,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic [PTR_BITS:0]     high_water
);

  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] ZERO_C  = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] ONE_C   = CNT_BITS'(1'b1);
  localparam logic [CNT_BITS-1:0] TWO_C   = CNT_BITS'(2'd2);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_REPL  = 3'b011;
  localparam logic [2:0] OP_BINOP = 3'b100;
  localparam logic [2:0] OP_DUP   = 3'b101;
  localparam logic [2:0] OP_SWAP  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  logic [REG_BITS-1:0] entries_r [DEPTH];
  logic [CNT_BITS-1:0] count_r;
  logic [CNT_BITS-1:0] hw_r;
  logic                op_ok_r;
  logic                op_err_r;
  logic                ovf_r;
  logic                unf_r;

  logic [PTR_BITS-1:0] top_idx_s;
  logic [PTR_BITS-1:0] nos_idx_s;
  logic [PTR_BITS-1:0] push_idx_s;
  logic [REG_BITS-1:0] tos_s;
  logic [REG_BITS-1:0] nos_s;
  logic                has1_s;
  logic                has2_s;
  logic                room_s;

  logic                ok_s;
  logic                ovf_s;
  logic                unf_s;
  logic                clr_s;
  logic [CNT_BITS-1:0] count_nx_s;
  logic                wa_en_s;
  logic [PTR_BITS-1:0] wa_idx_s;
  logic [REG_BITS-1:0] wa_data_s;
  logic                wb_en_s;
  logic [PTR_BITS-1:0] wb_idx_s;
  logic [REG_BITS-1:0] wb_data_s;

  // Only the low pointer bits address the file; count==DEPTH never indexes a write.
  assign top_idx_s  = PTR_BITS'(count_r - ONE_C);
  assign nos_idx_s  = PTR_BITS'(count_r - TWO_C);
  assign push_idx_s = count_r[PTR_BITS-1:0];

  assign has1_s = (count_r != ZERO_C);
  assign has2_s = (count_r >= TWO_C);
  assign room_s = (count_r < DEPTH_C);

  assign tos_s = has1_s ? entries_r[top_idx_s] : {REG_BITS{1'b0}};
  assign nos_s = has2_s ? entries_r[nos_idx_s] : {REG_BITS{1'b0}};

  assign tos           = tos_s;
  assign nos           = nos_s;
  assign count         = count_r;
  assign empty         = ~has1_s;
  assign full          = (count_r == DEPTH_C);
  assign op_ok         = op_ok_r;
  assign op_err        = op_err_r;
  assign err_overflow  = ovf_r;
  assign err_underflow = unf_r;
  assign high_water    = hw_r;

  // Decode the op into legality, next count and up to two entry writes (SWAP needs both).
  always_comb begin
    ok_s       = 1'b0;
    ovf_s      = 1'b0;
    unf_s      = 1'b0;
    clr_s      = 1'b0;
    count_nx_s = count_r;
    wa_en_s    = 1'b0;
    wa_idx_s   = push_idx_s;
    wa_data_s  = wdata;
    wb_en_s    = 1'b0;
    wb_idx_s   = nos_idx_s;
    wb_data_s  = tos_s;
    if (op_valid) begin
      case (op)
        OP_NOP: begin
          ok_s = 1'b0;
        end
        OP_PUSH: begin
          if (room_s) begin
            ok_s       = 1'b1;
            wa_en_s    = 1'b1;
            wa_idx_s   = push_idx_s;
            wa_data_s  = wdata;
            count_nx_s = count_r + ONE_C;
          end else begin
            ovf_s = 1'b1;
          end
        end
        OP_POP: begin
          if (has1_s) begin
            ok_s       = 1'b1;
            count_nx_s = count_r - ONE_C;
          end else begin
            unf_s = 1'b1;
          end
        end
        OP_REPL: begin
          if (has1_s) begin
            ok_s      = 1'b1;
            wa_en_s   = 1'b1;
            wa_idx_s  = top_idx_s;
            wa_data_s = wdata;
          end else begin
            unf_s = 1'b1;
          end
        end
        OP_BINOP: begin
          if (has2_s) begin
            ok_s       = 1'b1;
            wa_en_s    = 1'b1;
            wa_idx_s   = nos_idx_s;
            wa_data_s  = wdata;
            count_nx_s = count_r - ONE_C;
          end else begin
            unf_s = 1'b1;
          end
        end
        OP_DUP: begin
          if (!has1_s) begin
            unf_s = 1'b1;
          end else if (!room_s) begin
            ovf_s = 1'b1;
          end else begin
            ok_s       = 1'b1;
            wa_en_s    = 1'b1;
            wa_idx_s   = push_idx_s;
            wa_data_s  = tos_s;
            count_nx_s = count_r + ONE_C;
          end
        end
        OP_SWAP: begin
          if (has2_s) begin
            ok_s      = 1'b1;
            wa_en_s   = 1'b1;
            wa_idx_s  = top_idx_s;
            wa_data_s = nos_s;
            wb_en_s   = 1'b1;
            wb_idx_s  = nos_idx_s;
            wb_data_s = tos_s;
          end else begin
            unf_s = 1'b1;
          end
        end
        OP_CLEAR: begin
          ok_s       = 1'b1;
          clr_s      = 1'b1;
          count_nx_s = ZERO_C;
        end
        default: begin
          ok_s = 1'b0;
        end
      endcase
    end else begin
      count_nx_s = count_r;
    end
  end

  // Entry file: cleared on reset, written by the decoded write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= {REG_BITS{1'b0}};
      end
    end else begin
      if (wa_en_s) begin
        entries_r[wa_idx_s] <= wa_data_s;
      end
      if (wb_en_s) begin
        entries_r[wb_idx_s] <= wb_data_s;
      end
    end
  end

  // Occupancy and high-water mark; count never exceeds DEPTH so the mark saturates naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO_C;
      hw_r    <= ZERO_C;
    end else begin
      count_r <= count_nx_s;
      if (clr_s) begin
        hw_r <= ZERO_C;
      end else if (ok_s && (count_nx_s > hw_r)) begin
        hw_r <= count_nx_s;
      end
    end
  end

  // Status pulses and sticky flags; a new error wins over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_ok_r  <= 1'b0;
      op_err_r <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      op_ok_r  <= ok_s;
      op_err_r <= ovf_s | unf_s;
      ovf_r    <= ovf_s | (ovf_r & ~clear_err);
      unf_r    <= unf_s | (unf_r & ~clear_err);
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed plus random stimulus for stack_unit (DEPTH=4) checked against a queue-based model.
module tb_stack_unit;

  localparam int RB = 32;
  localparam int DP = 4;
  localparam int PB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [RB-1:0] wdata = '0;
  logic          clear_err = 1'b0;
  logic [RB-1:0] tos, nos;
  logic [PB:0]   count, high_water;
  logic          empty, full, op_ok, op_err, err_overflow, err_underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] stk[$];
  int          m_hw;
  bit          m_ok, m_err, m_ovf, m_unf;

  stack_unit #(.REG_BITS(RB), .DEPTH(DP), .PTR_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .wdata(wdata),
    .clear_err(clear_err), .tos(tos), .nos(nos), .count(count), .empty(empty),
    .full(full), .op_ok(op_ok), .op_err(op_err), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .high_water(high_water)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_hw = 0; m_ok = 0; m_err = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Stack semantics expressed directly on a queue whose last element is the top.
  task automatic model_step(input bit v, input logic [2:0] o, input logic [31:0] w, input bit ce);
    bit ok, ov, un;
    int n;
    logic [31:0] t;
    ok = 0; ov = 0; un = 0; n = stk.size();
    if (v) begin
      case (o)
        3'd1: if (n < DP) begin stk.push_back(w); ok = 1; end else ov = 1;
        3'd2: if (n >= 1) begin t = stk.pop_back(); ok = 1; end else un = 1;
        3'd3: if (n >= 1) begin stk[n-1] = w; ok = 1; end else un = 1;
        3'd4: if (n >= 2) begin t = stk.pop_back(); stk[n-2] = w; ok = 1; end else un = 1;
        3'd5: if (n == 0) un = 1;
              else if (n == DP) ov = 1;
              else begin stk.push_back(stk[n-1]); ok = 1; end
        3'd6: if (n >= 2) begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; ok = 1; end
              else un = 1;
        3'd7: begin stk.delete(); m_hw = 0; ok = 1; end
        default: ok = 0;
      endcase
    end
    m_ok = ok;
    m_err = ov | un;
    if (ce) begin m_ovf = 0; m_unf = 0; end
    if (ov) m_ovf = 1;
    if (un) m_unf = 1;
    if (ok && o != 3'd7 && stk.size() > m_hw) m_hw = stk.size();
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [31:0] et, en;
    n = stk.size();
    et = (n >= 1) ? stk[n-1] : 32'd0;
    en = (n >= 2) ? stk[n-2] : 32'd0;
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".tos"}, tos, et);
    chk({tag, ".nos"}, nos, en);
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DP));
    chk({tag, ".op_ok"}, 32'(op_ok), 32'(m_ok));
    chk({tag, ".op_err"}, 32'(op_err), 32'(m_err));
    chk({tag, ".ovf"}, 32'(err_overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(err_underflow), 32'(m_unf));
    chk({tag, ".hw"}, 32'(high_water), 32'(m_hw));
  endtask

  task automatic do_op(input string tag, input bit v, input logic [2:0] o,
                       input logic [31:0] w, input bit ce);
    @(negedge clk);
    op_valid = v; op = o; wdata = w; clear_err = ce;
    @(posedge clk);
    model_step(v, o, w, ce);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset");
    do_op("idle", 1'b0, 3'd0, 32'd0, 1'b0);

    // Basic data movement
    do_op("push3", 1'b1, 3'd1, 32'd3, 1'b0);
    do_op("pushFE", 1'b1, 3'd1, 32'hFFFF_FFFE, 1'b0);
    chk("plan.tos_fe", tos, 32'hFFFF_FFFE);
    do_op("swap", 1'b1, 3'd6, 32'd0, 1'b0);
    chk("plan.swap_tos", tos, 32'd3);
    do_op("binop", 1'b1, 3'd4, 32'hFFFF_FFFB, 1'b0);
    chk("plan.binop_tos", tos, 32'hFFFF_FFFB);
    do_op("repl", 1'b1, 3'd3, 32'h1234_5678, 1'b0);
    do_op("nop", 1'b1, 3'd0, 32'd99, 1'b0);
    do_op("clear0", 1'b1, 3'd7, 32'd0, 1'b0);

    // Overflow
    for (int i = 1; i <= 4; i++) do_op("fill", 1'b1, 3'd1, 32'(i), 1'b0);
    do_op("push5", 1'b1, 3'd1, 32'd5, 1'b0);
    chk("plan.ovf_tos", tos, 32'd4);
    do_op("dup_full", 1'b1, 3'd5, 32'd0, 1'b0);
    chk("plan.hw4", 32'(high_water), 32'd4);
    do_op("clear1", 1'b1, 3'd7, 32'd0, 1'b1);

    // Underflow and sticky clear precedence
    do_op("pop_empty", 1'b1, 3'd2, 32'd0, 1'b0);
    do_op("dup_empty", 1'b1, 3'd5, 32'd0, 1'b0);
    do_op("push7", 1'b1, 3'd1, 32'd7, 1'b0);
    do_op("binop1", 1'b1, 3'd4, 32'd11, 1'b0);
    chk("plan.binop1_tos", tos, 32'd7);
    do_op("swap1", 1'b1, 3'd6, 32'd0, 1'b0);
    do_op("pop7", 1'b1, 3'd2, 32'd0, 1'b0);
    do_op("clr_and_pop", 1'b1, 3'd2, 32'd0, 1'b1);
    chk("plan.sticky_set", 32'(err_underflow), 32'd1);
    do_op("clr_alone", 1'b0, 3'd0, 32'd0, 1'b1);
    chk("plan.sticky_clr", 32'(err_underflow), 32'd0);

    // Asynchronous reset between edges
    do_op("push9", 1'b1, 3'd1, 32'd9, 1'b0);
    do_op("push10", 1'b1, 3'd1, 32'd10, 1'b0);
    op_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("refill_a", 1'b1, 3'd1, 32'hA5A5_A5A5, 1'b0);
    do_op("refill_b", 1'b1, 3'd5, 32'd0, 1'b0);
    do_op("clear_hw", 1'b1, 3'd7, 32'd0, 1'b0);
    chk("plan.hw0", 32'(high_water), 32'd0);

    // Random operations
    for (int i = 0; i < 400; i++) begin
      do_op("rand", ($urandom % 8) != 0, 3'($urandom_range(0, 7)), $urandom,
            ($urandom % 6) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Parametrised register-file operand stack for the stack machine datapath; replaces the fixed-size stack/stack-pointer pair.
- Exposes top-of-stack (TOS) and next-on-stack (NOS) every cycle.
- Executes one stack operation per clock.
- Detects overflow/underflow and tracks a high-water mark for firmware sizing.

Parameters:
REG_BITS  32  data word width
DEPTH  16  number of stack entries, power of two, >= 2
PTR_BITS  4  log2(DEPTH); count width is PTR_BITS+1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op_valid  input  1  op is executed on this rising edge
op  input  3  000 NOP, 001 PUSH, 010 POP, 011 REPL, 100 BINOP, 101 DUP, 110 SWAP, 111 CLEAR
wdata  input  REG_BITS  value for PUSH/REPL/BINOP
clear_err  input  1  clears sticky error flags
tos  output  REG_BITS  entry[count-1]; 0 when count==0
nos  output  REG_BITS  entry[count-2]; 0 when count<2
count  output  PTR_BITS+1  occupied entries, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
op_ok  output  1  registered 1-cycle pulse: previous op accepted
op_err  output  1  registered 1-cycle pulse: previous op rejected
err_overflow  output  1  sticky
err_underflow  output  1  sticky
high_water  output  PTR_BITS+1  maximum count reached since reset/CLEAR

Behaviour:
- Reset (async, rst_n=0):
  - count, high_water, all entries, op_ok, op_err, err_overflow and err_underflow go to 0 immediately.
  - tos and nos read 0.
  - Releasing reset mid-operation loses the operation; the first edge after release executes normally.
- State changes only on a rising clk with op_valid=1. op_valid=0 or NOP: no change, op_ok=op_err=0.
- tos/nos/empty/full are combinational from registered state and reflect the result in the same cycle after the edge (0-cycle read latency).
- Ops, with their legality condition; an illegal op leaves entries and count unchanged:
  - PUSH: needs count<DEPTH. entry[count]<=wdata, count+1. Otherwise overflow.
  - POP: needs count>=1. count-1; the popped data is tos before the edge. Otherwise underflow.
  - REPL: needs count>=1. entry[count-1]<=wdata. Otherwise underflow.
  - BINOP: needs count>=2. entry[count-2]<=wdata, count-1. This is the "pop two, push ALU result" used by add/sub/xor. Otherwise underflow.
  - DUP: needs 1<=count<DEPTH. entry[count]<=tos, count+1. count==0 is underflow; count==DEPTH is overflow.
  - SWAP: needs count>=2. Exchanges entry[count-1] and entry[count-2]. Otherwise underflow.
  - CLEAR: always legal. count<=0 and high_water<=0; entries are not required to be zeroed, but tos/nos must read 0.
- On the edge after an op: op_ok=1 if legal, op_err=1 if illegal. Never both; each lasts one cycle.
- Sticky flags:
  - Set on an illegal op of the matching kind.
  - Cleared by clear_err=1 at an edge.
  - If clear_err and a new error occur at the same edge, the flag ends set. The other flag still clears.
- high_water <= max(high_water, new count) on every legal op except CLEAR. It saturates at DEPTH.
- Arithmetic: count math is unsigned PTR_BITS+1 and never wraps; the illegal checks prevent it. Entry indices use the low PTR_BITS bits.
- No data transformation: wdata is stored bit-exact at REG_BITS.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> count=0, empty=1, tos=nos=0, all flags 0, high_water=0.
- DEPTH=4, REG_BITS=32:
  - PUSH 3, then PUSH 0xFFFFFFFE -> tos=0xFFFFFFFE, nos=3, count=2.
  - Then SWAP -> tos=3, nos=0xFFFFFFFE.
  - Then BINOP wdata=0xFFFFFFFB -> count=1, tos=0xFFFFFFFB, op_ok pulses each op.
- Overflow: PUSH 1,2,3,4 then PUSH 5 -> count=4, full=1, tos=4, op_err=1, err_overflow=1. Then DUP -> still overflow, count=4, high_water=4.
- Underflow: from empty, POP -> op_err=1, err_underflow=1, count=0. Then BINOP with count=1 (after PUSH 7) -> rejected, tos=7.
- Sticky clear: with err_underflow=1, assert clear_err together with an illegal POP on empty -> err_underflow stays 1. clear_err alone next cycle -> 0.
- Async reset mid-sequence: PUSH 9, PUSH 10, then drop rst_n between edges -> count=0 and tos=0 before the next edge. CLEAR after refill -> high_water=0.
